udma_hyper_evt_sequencer: RTL and testbench

//  Classifies HyperBus end-of-transfer (EOT) pulses into read-EOT and write-EOT events.
//  It queues the direction of every launched transaction and pops one entry per EOT.

---
 rtl/udma_hyper_evt_sequencer_if.sv | 34 +++
 rtl/udma_hyper_evt_sequencer.sv | 90 +++++++++
 tb/tb_udma_hyper_evt_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/udma_hyper_evt_sequencer_if.sv
// rtl/udma_hyper_evt_sequencer_if.sv - transaction/EOT/event bundle of the hyper EOT sequencer
// master drives transaction starts and EOTs; slave is the sequencer itself.
interface udma_hyper_evt_sequencer_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
);
   localparam int PEND_W = $clog2(DEPTH + 1);

   logic              txn_start_i;
   logic              txn_is_read_i;
   logic              txn_ready_o;
   logic              hyper_eot_i;
   logic              evt_rd_eot_o;
   logic              evt_wr_eot_o;
   logic [PEND_W-1:0] pending_o;
   logic [CNT_W-1:0]  rd_done_cnt_o;
   logic [CNT_W-1:0]  wr_done_cnt_o;
   logic              cnt_clr_i;
   logic              err_overflow_o;
   logic              err_spurious_o;
   logic              err_clr_i;

   modport master (
      output txn_start_i, txn_is_read_i, hyper_eot_i, cnt_clr_i, err_clr_i,
      input  txn_ready_o, evt_rd_eot_o, evt_wr_eot_o, pending_o,
             rd_done_cnt_o, wr_done_cnt_o, err_overflow_o, err_spurious_o
   );

   modport slave (
      input  txn_start_i, txn_is_read_i, hyper_eot_i, cnt_clr_i, err_clr_i,
      output txn_ready_o, evt_rd_eot_o, evt_wr_eot_o, pending_o,
             rd_done_cnt_o, wr_done_cnt_o, err_overflow_o, err_spurious_o
   );
endinterface

// File: rtl/udma_hyper_evt_sequencer.sv
// rtl/udma_hyper_evt_sequencer.sv - classifies hyper EOT pulses into read/write events
// Direction FIFO pushed on each launched transaction, popped once per EOT.
module udma_hyper_evt_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      sys_clk_i,
   input  logic                      rstn_i,
   udma_hyper_evt_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DEPTH-1:0] fifo_q, fifo_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic             evt_rd_q, evt_rd_d, evt_wr_q, evt_wr_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic             err_ovf_q, err_ovf_d, err_sp_q, err_sp_d;

   logic [PW-1:0]    count;
   logic             full, empty, push, pop, head;

   // Pointer MSB disambiguates full from empty once the indices wrap.
   assign count = wptr_q - rptr_q;
   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.txn_start_i & ~full;
   assign pop   = bus.hyper_eot_i & ~empty;
   assign head  = fifo_q[rptr_q[AW-1:0]];

   always_comb begin
      fifo_d   = fifo_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (push) begin
         fifo_d[wptr_q[AW-1:0]] = bus.txn_is_read_i;
         wptr_d                 = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      // Head is read from pre-cycle state, so a same-cycle push can never be popped.
      evt_rd_d = pop & head;
      evt_wr_d = pop & ~head;
      if (bus.cnt_clr_i) begin
         rd_cnt_d = '0;
         wr_cnt_d = '0;
      end else begin
         if (evt_rd_d && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
         if (evt_wr_d && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      err_ovf_d = (bus.txn_start_i & full)  | (err_ovf_q & ~bus.err_clr_i);
      err_sp_d  = (bus.hyper_eot_i & empty) | (err_sp_q  & ~bus.err_clr_i);
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         fifo_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         evt_rd_q  <= 1'b0;
         evt_wr_q  <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_ovf_q <= 1'b0;
         err_sp_q  <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         evt_rd_q  <= evt_rd_d;
         evt_wr_q  <= evt_wr_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_ovf_q <= err_ovf_d;
         err_sp_q  <= err_sp_d;
      end
   end

   assign bus.txn_ready_o    = ~full;
   assign bus.pending_o      = count;
   assign bus.evt_rd_eot_o   = evt_rd_q;
   assign bus.evt_wr_eot_o   = evt_wr_q;
   assign bus.rd_done_cnt_o  = rd_cnt_q;
   assign bus.wr_done_cnt_o  = wr_cnt_q;
   assign bus.err_overflow_o = err_ovf_q;
   assign bus.err_spurious_o = err_sp_q;
endmodule

// File: tb/tb_udma_hyper_evt_sequencer.sv
// tb/tb_udma_hyper_evt_sequencer.sv - directed and random bench for udma_hyper_evt_sequencer
// Reference model: a queue of direction bits plus plain counters and flags.
module tb_udma_hyper_evt_sequencer;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rstn;

   udma_hyper_evt_sequencer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   udma_hyper_evt_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .sys_clk_i (clk),
      .rstn_i    (rstn),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   bit mq[$];
   bit m_rd, m_wr, m_ovf, m_sp;
   int m_rdc, m_wrc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_rd = 0; m_wr = 0; m_ovf = 0; m_sp = 0;
      m_rdc = 0; m_wrc = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".evt_rd"},  32'(bus.evt_rd_eot_o),   32'(m_rd));
      chk({tag, ".evt_wr"},  32'(bus.evt_wr_eot_o),   32'(m_wr));
      chk({tag, ".pending"}, 32'(bus.pending_o),      32'(mq.size()));
      chk({tag, ".ready"},   32'(bus.txn_ready_o),    32'(mq.size() != DEPTH));
      chk({tag, ".rd_cnt"},  32'(bus.rd_done_cnt_o),  32'(m_rdc));
      chk({tag, ".wr_cnt"},  32'(bus.wr_done_cnt_o),  32'(m_wrc));
      chk({tag, ".err_ovf"}, 32'(bus.err_overflow_o), 32'(m_ovf));
      chk({tag, ".err_sp"},  32'(bus.err_spurious_o), 32'(m_sp));
   endtask

   // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input string tag, input bit s, input bit r, input bit e,
                        input bit cc, input bit ec);
      bit was_full, was_empty, b;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      bus.txn_start_i   = s;
      bus.txn_is_read_i = r;
      bus.hyper_eot_i   = e;
      bus.cnt_clr_i     = cc;
      bus.err_clr_i     = ec;
      m_rd = 0; m_wr = 0;
      if (e && !was_empty) begin
         b = mq.pop_front();
         m_rd = b; m_wr = !b;
      end
      if (s && !was_full) mq.push_back(r);
      if (cc) begin
         m_rdc = 0; m_wrc = 0;
      end else begin
         if (m_rd && m_rdc < CMAX) m_rdc++;
         if (m_wr && m_wrc < CMAX) m_wrc++;
      end
      if (s && was_full) m_ovf = 1; else if (ec) m_ovf = 0;
      if (e && was_empty) m_sp = 1;  else if (ec) m_sp = 0;
      @(posedge clk);
      #1;
      bus.txn_start_i = 0; bus.hyper_eot_i = 0; bus.cnt_clr_i = 0; bus.err_clr_i = 0;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rstn = 1'b0;
      bus.txn_start_i = 0; bus.txn_is_read_i = 0; bus.hyper_eot_i = 0;
      bus.cnt_clr_i = 0; bus.err_clr_i = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rstn = 1'b1;

      // T1 ordering
      cycle("t1_push", 1, 1, 0, 0, 0);
      cycle("t1_push", 1, 0, 0, 0, 0);
      cycle("t1_push", 1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle("t1_eot", 0, 0, 1, 0, 0);
         idle("t1_gap", 9);
      end

      // T2 full / overflow / spurious
      for (int k = 0; k < 5; k++) cycle("t2_push", 1, 0, 0, 0, 0);
      cycle("t2_eclr", 0, 0, 0, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cycle("t2_eot", 0, 0, 1, 0, 0);
         idle("t2_gap", 1);
      end
      cycle("t2_set_vs_clr", 0, 0, 1, 0, 1);
      cycle("t2_eclr", 0, 0, 0, 0, 1);

      // T3 simultaneous push+pop
      cycle("t3_push", 1, 1, 0, 0, 0);
      cycle("t3_both", 1, 0, 1, 0, 0);
      cycle("t3_eot", 0, 0, 1, 0, 0);
      idle("t3_idle", 2);

      // Full queue plus push+pop: the push must be dropped
      for (int k = 0; k < DEPTH; k++) cycle("full_push", 1, k[0], 0, 0, 0);
      cycle("full_both", 1, 1, 1, 0, 0);
      for (int k = 0; k < DEPTH; k++) cycle("full_drain", 0, 0, 1, 0, 0);
      cycle("full_eclr", 0, 0, 0, 0, 1);

      // T4 pointer wrap
      for (int k = 0; k < 3 * DEPTH + 1; k++) begin
         cycle("t4_push", 1, ~k[0], 0, 0, 0);
         cycle("t4_eot", 0, 0, 1, 0, 0);
      end

      // T5 saturation and clear priority
      cycle("t5_clr", 0, 0, 0, 1, 0);
      for (int k = 0; k < 17; k++) begin
         cycle("t5_push", 1, 1, 0, 0, 0);
         cycle("t5_eot", 0, 0, 1, 0, 0);
      end
      cycle("t5_push", 1, 1, 0, 0, 0);
      cycle("t5_eot_clr", 0, 0, 1, 1, 0);
      idle("t5_idle", 1);

      // T6 asynchronous reset mid-flight
      cycle("t6_push", 1, 1, 0, 0, 0);
      cycle("t6_push", 1, 0, 0, 0, 0);
      cycle("t6_push", 1, 1, 0, 0, 0);
      #3;
      rstn = 1'b0;
      m_reset();
      #1;
      check_all("t6_async");
      #2;
      rstn = 1'b1;
      cycle("t6_eot", 0, 0, 1, 0, 0);
      idle("t6_idle", 3);
      cycle("t6_eclr", 0, 0, 0, 0, 1);

      // Random traffic against the queue model
      for (int k = 0; k < 400; k++) begin
         cycle("rand",
               $urandom_range(0, 99) < 45,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 40,
               $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 5);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
